// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types and constants for the IO bus arbiter.
// Provides the arbiter FSM state type, master indices and peripheral word addresses.
package io_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} io_arb_state_t;
  localparam int M_CPU = 0;
  localparam int M_DBG = 1;
  localparam logic [29:0] IO_PB_WADDR  = 30'h2000_0000;
  localparam logic [29:0] IO_LED_WADDR = 30'h2000_0001;
endpackage

// File: rtl/io_arb_pick2.sv
// io_arb_pick2: combinational two-way priority pick.
// Ports: req (per-master request), ptr (favoured master on a tie), win (one-hot winner, 0 if no request).
module io_arb_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  always_comb begin
    win[0] = req[0] & (~ptr | ~req[1]);
    win[1] = req[1] & (ptr | ~req[0]);
  end
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master arbiter and IDLE/ISSUE/RESP sequencer for the registered-read IO port.
// Ports: clk, reset_n (async, active-low); m_req/m_addr/m_wdata/m_we/m_be per-master command,
// m_gnt/m_done one-hot pulses, m_rdata shared read data; io_addr/io_wdata/io_we/io_be to the
// peripheral, io_rdata from it (valid one cycle after the address).
// Build option: define IO_ARB_RR_EN for round-robin ties; otherwise master 0 has fixed priority.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          m_req,
  input  logic [1:0][AW-1:0]  m_addr,
  input  logic [1:0][DW-1:0]  m_wdata,
  input  logic [1:0]          m_we,
  input  logic [1:0][3:0]     m_be,
  output logic [1:0]          m_gnt,
  output logic [1:0]          m_done,
  output logic [DW-1:0]       m_rdata,
  output logic [AW-1:0]       io_addr,
  output logic [DW-1:0]       io_wdata,
  output logic                io_we,
  output logic [3:0]          io_be,
  input  logic [DW-1:0]       io_rdata
);
  io_arb_state_t r_state, w_next;
  logic [1:0]    w_win;
  logic          w_ptr, w_go, r_win, r_we;
  logic [3:0]    r_be;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  io_arb_pick2 u_pick (.req(m_req), .ptr(w_ptr), .win(w_win));

  assign w_go = (r_state == IDLE) && (|w_win);

`ifdef IO_ARB_RR_EN
  // Pointer names the favoured master; the one just granted drops to lowest priority.
  logic r_ptr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_ptr <= 1'b0;
    else if (w_go) r_ptr <= ~w_win[M_DBG];
  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_go ? ISSUE : IDLE;
    else if (r_state == ISSUE) w_next = RESP;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'b0;
      r_win   <= 1'b0;
    end else if (w_go) begin
      r_addr  <= m_addr[w_win[M_DBG]];
      r_wdata <= m_wdata[w_win[M_DBG]];
      r_we    <= m_we[w_win[M_DBG]];
      r_be    <= m_be[w_win[M_DBG]];
      r_win   <= w_win[M_DBG];
    end

  // Strobes are qualified by state so the peripheral never sees a write outside ISSUE.
  always_comb begin
    io_addr  = r_addr;
    io_wdata = r_wdata;
    io_we    = (r_state == ISSUE) & r_we;
    io_be    = (r_state == ISSUE) ? r_be : 4'b0;
    m_gnt    = (r_state == ISSUE) ? {r_win, ~r_win} : 2'b0;
    m_done   = (r_state == RESP) ? {r_win, ~r_win} : 2'b0;
    m_rdata  = (r_state == RESP && !r_we) ? io_rdata : '0;
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: self-checking bench for io_bus_arbiter with a transaction-level reference model.
module tb_io_bus_arbiter;
  import io_bus_pkg::*;
  localparam int AW = 30;
  localparam int DW = 32;
`ifdef IO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] m_req = '0;
  logic [1:0][AW-1:0] m_addr = '0;
  logic [1:0][DW-1:0] m_wdata = '0;
  logic [1:0] m_we = '0;
  logic [1:0][3:0] m_be = '0;
  logic [1:0] m_gnt, m_done;
  logic [DW-1:0] m_rdata, io_wdata;
  logic [AW-1:0] io_addr;
  logic io_we;
  logic [3:0] io_be;
  logic [DW-1:0] io_rdata = '0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_we(m_we), .m_be(m_be), .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_be(io_be), .io_rdata(io_rdata)
  );

  logic [DW-1:0] led = '0;
  logic [3:0] pb = 4'h5;

  function automatic logic [DW-1:0] periph(input logic [AW-1:0] a, input logic [DW-1:0] l, input logic [3:0] p);
    return a == IO_PB_WADDR ? {28'b0, p} : a == IO_LED_WADDR ? l : {a, 2'b00} ^ 32'h5A5A_A5A5;
  endfunction

  always @(posedge clk) begin
    io_rdata <= periph(io_addr, led, pb);
    if (io_we && io_addr == IO_LED_WADDR) led <= io_wdata;
  end

  int checks = 0, errors = 0;
  int cyc = 0, free_at = 0, g_t = -100, w = 0, ptr_m = 0, mode = 0;
  logic e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata, model_led = '0;
  logic [3:0] e_be;
  int gq[$];
  int gtime[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic newtxn(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    m_req[i] = 1'b1;
    m_we[i] = we;
    m_addr[i] = a;
    m_wdata[i] = d;
    m_be[i] = be;
  endtask

  task automatic rand_txn(input int i);
    int k;
    logic [AW-1:0] a;
    k = $urandom_range(0, 3);
    a = k == 0 ? IO_PB_WADDR : k == 1 ? IO_LED_WADDR : AW'($urandom);
    newtxn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
  endtask

  // One clock: the model decides what the arbiter must do with the requests seen at this edge,
  // then every output is compared, then the masters react.
  task automatic cycle();
    logic [1:0] r;
    logic [1:0] eg, ed;
    r = m_req;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= free_at && r != 2'b00) begin
      w = r == 2'b11 ? ptr_m : (r[1] ? 1 : 0);
      ptr_m = RR ? 1 - w : 0;
      g_t = cyc;
      free_at = cyc + 3;
      e_we = m_we[w];
      e_addr = m_addr[w];
      e_wdata = m_wdata[w];
      e_be = m_be[w];
      e_rdata = e_we ? '0 : periph(e_addr, model_led, pb);
      if (e_we && e_addr == IO_LED_WADDR) model_led = e_wdata;
      gq.push_back(w);
      gtime.push_back(cyc);
    end
    eg = cyc == g_t ? 2'(1 << w) : 2'b00;
    ed = cyc == g_t + 1 ? 2'(1 << w) : 2'b00;
    chk("m_gnt", m_gnt, eg);
    chk("m_done", m_done, ed);
    chk("m_rdata", m_rdata, cyc == g_t + 1 ? e_rdata : '0);
    chk("io_we", io_we, cyc == g_t && e_we);
    chk("io_be", io_be, cyc == g_t ? e_be : 4'b0);
    if (cyc == g_t) begin
      chk("io_addr", io_addr, e_addr);
      chk("io_wdata", io_wdata, e_wdata);
      if (mode == 0) m_req[w] = 1'b0;
      else if (mode == 2) begin
        if ($urandom_range(0, 1) == 1) rand_txn(w);
        else m_req[w] = 1'b0;
      end
    end
    if (mode == 2)
      for (int i = 0; i < 2; i++)
        if (!m_req[i] && $urandom_range(0, 9) < 3) rand_txn(i);
  endtask

  initial begin
    #1;
    chk("rst m_gnt", m_gnt, 2'b00);
    chk("rst m_done", m_done, 2'b00);
    chk("rst m_rdata", m_rdata, 32'h0);
    chk("rst io_addr", io_addr, 30'h0);
    chk("rst io_wdata", io_wdata, 32'h0);
    chk("rst io_we", io_we, 1'b0);
    chk("rst io_be", io_be, 4'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    newtxn(M_CPU, 1'b1, IO_LED_WADDR, 32'h3FF, 4'b0011);
    repeat (4) cycle();
    chk("led write", led, 32'h3FF);
    chk("led grant", gq.size() == 1 && gq[0] == 0, 1'b1);

    gq.delete();
    gtime.delete();
    newtxn(M_DBG, 1'b0, IO_PB_WADDR, 32'h0, 4'hF);
    cycle();
    chk("pb read gnt", m_gnt, 2'b10);
    cycle();
    chk("pb read data", m_rdata, 32'h5);
    repeat (2) cycle();

    gq.delete();
    gtime.delete();
    mode = 1;
    newtxn(M_CPU, 1'b0, IO_PB_WADDR, 32'h0, 4'hF);
    newtxn(M_DBG, 1'b0, IO_LED_WADDR, 32'h0, 4'hF);
    repeat (12) cycle();
    m_req = 2'b00;
    mode = 0;
    repeat (2) cycle();
    chk("contention count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      chk("contention order", gq[i], RR ? i % 2 : 0);
      if (i > 0) chk("contention spacing", gtime[i] - gtime[i-1], 3);
    end

    gq.delete();
    gtime.delete();
    newtxn(M_CPU, 1'b1, 30'h0000_0123, 32'hCAFE_0001, 4'hF);
    cycle();
    newtxn(M_DBG, 1'b1, 30'h0000_0456, 32'hCAFE_0002, 4'hC);
    repeat (5) cycle();
    chk("late order", gq.size() == 2 && gq[0] == 0 && gq[1] == 1, 1'b1);
    if (gtime.size() == 2) chk("late spacing", gtime[1] - gtime[0], 3);

    gq.delete();
    gtime.delete();
    newtxn(M_CPU, 1'b0, IO_LED_WADDR, 32'h0, 4'hF);
    newtxn(M_DBG, 1'b0, IO_PB_WADDR, 32'h0, 4'hF);
    repeat (2) cycle();
    reset_n = 1'b0;
    #1;
    chk("rstresp m_done", m_done, 2'b00);
    chk("rstresp m_gnt", m_gnt, 2'b00);
    chk("rstresp m_rdata", m_rdata, 32'h0);
    chk("rstresp io_addr", io_addr, 30'h0);
    chk("rstresp io_wdata", io_wdata, 32'h0);
    chk("rstresp io_we", io_we, 1'b0);
    chk("rstresp io_be", io_be, 4'b0);
    @(negedge clk);
    reset_n = 1'b1;
    g_t = -100;
    ptr_m = 0;
    free_at = cyc + 1;
    gq.delete();
    gtime.delete();
    cycle();
    chk("post-reset grant", m_gnt, 2'b10);
    repeat (3) cycle();

    mode = 2;
    repeat (400) cycle();
    mode = 0;
    m_req = 2'b00;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
